// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequencer for an SA_SIZE x SA_SIZE output-stationary systolic
// array. It clears the PE accumulators, steps the operand wavefront through
// K + 2N - 2 steps (stalling only while operands are needed but not valid),
// then presents the accumulators as results until the consumer takes them.
//
// Optional feature: define PE_CTRL_PERF_EN to add stall_cnt_o, a saturating
// 32-bit count of stall cycles in the current job.
module pe_array_ctrl #(
    parameter int SA_SIZE = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   mat_width_i,
    input  logic               in_valid_i,
    input  logic               result_ready_i,
    output logic               pe_clr_o,
    output logic               pe_hold_o,
    output logic [SA_SIZE-1:0] feed_en_o,
    output logic [CNT_W:0]     step_o,
    output logic               busy_o,
    output logic               result_valid_o,
`ifdef PE_CTRL_PERF_EN
    output logic [31:0]        stall_cnt_o,
`endif
    output logic               done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DONE
    } state_e;

    // Two extra bits so that step, K + lane index and the last step value can
    // be compared without any risk of overflow.
    localparam int EXT_W = CNT_W + 2;

    state_e             state_q;
    logic [CNT_W-1:0]   k_q;
    logic [CNT_W:0]     step_q;
    logic               clr_q;
    logic               busy_q;
    logic               rv_q;

    logic [EXT_W-1:0]   step_ext;
    logic [EXT_W-1:0]   k_ext;
    logic [EXT_W-1:0]   last_step;
    logic [SA_SIZE-1:0] feed_en_d;
    logic               need;
    logic               stall;

    assign step_ext  = EXT_W'(step_q);
    assign k_ext     = EXT_W'(k_q);
    assign last_step = k_ext + EXT_W'(2 * SA_SIZE - 3);

    // Lane i carries operand t-i, which exists only while 0 <= t-i < K.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        feed_en_d = '0;
        for (int i = 0; i < SA_SIZE; i++) begin
            if (state_q == S_FEED &&
                step_ext >= EXT_W'(i) &&
                step_ext <  k_ext + EXT_W'(i)) begin
                feed_en_d[i] = 1'b1;
            end
        end
    end

    // Drain steps have no lane enabled, so they can never stall.
    assign need  = |feed_en_d;
    assign stall = need & ~in_valid_i;

    // Job sequencing: state, latched K, wavefront step and registered flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            step_q  <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        k_q     <= mat_width_i;
                        step_q  <= '0;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_q  <= 1'b0;
                    step_q <= '0;
                    if (k_q == '0) begin
                        rv_q    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (!stall) begin
                        step_q <= step_q + (CNT_W + 1)'(1);
                        if (step_ext == last_step) begin
                            rv_q    <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready_i) begin
                        rv_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating stall counter, restarted by each job's clear step.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == S_CLEAR) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign feed_en_o      = feed_en_d;
    assign step_o         = step_q;
    assign pe_clr_o       = clr_q;
    assign busy_o         = busy_q;
    assign result_valid_o = rv_q;
    // PEs freeze outside a job and on stalls; they run during clear and feed.
    assign pe_hold_o      = (state_q == S_FEED) ? stall : (state_q != S_CLEAR);
    // Handshake pulse in the DONE cycle itself, so a start in that cycle is
    // still seen in DONE and is dropped.
    assign done_o         = rv_q & result_ready_i;

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter SA_SIZE, default 4, the systolic array dimension N (N x N PEs); legal range 2..2^(CNT_W-1).
REQ-002 Parameter CNT_W, default 8, the width of the inner-dimension length K.
REQ-003 clk  in  1  the single clock; all state is updated on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  job request; honoured only in IDLE.
REQ-006 mat_width_i  in  CNT_W  inner dimension K; sampled only on an accepted start.
REQ-007 in_valid_i  in  1  the operand source presents valid data for the current step.
REQ-008 result_ready_i  in  1  the consumer accepts the accum_o results of the PE array.
REQ-009 pe_clr_o  out  1  drives clr_i of every PE.
REQ-010 pe_hold_o  out  1  drives hold_i of every PE.
REQ-011 feed_en_o  out  SA_SIZE  bit i means row-i a operand and column-i b operand are valid this step.
REQ-012 step_o  out  CNT_W+1  current wavefront step t; the operand index for lane i is t-i.
REQ-013 busy_o  out  1  high in any state other than IDLE.
REQ-014 result_valid_o  out  1  the PE accumulators hold the final results.
REQ-015 done_o  out  1  one-cycle pulse on the result handshake.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, FEED and DONE.
REQ-017 In IDLE with start_i=1, the block SHALL latch K = mat_width_i and enter CLEAR at the next edge; in other states start_i SHALL be ignored.
REQ-018 CLEAR SHALL last exactly 1 cycle, with pe_clr_o=1, pe_hold_o=0 and step reset to 0; pe_clr_o SHALL be 0 in all other states.
REQ-019 From CLEAR, the next state SHALL be FEED if K>0 and DONE if K=0.
REQ-020 In FEED, feed_en_o[i] SHALL equal 1 iff i <= t <= i+K-1 (combinational from t and K).
REQ-021 need = OR of feed_en_o; stall = need AND NOT in_valid_i.
REQ-022 In FEED, pe_hold_o SHALL equal stall (combinational), and t SHALL increment by 1 on every non-stall cycle.
REQ-023 Drain steps (t >= K+N-1, need=0) SHALL never stall, regardless of in_valid_i.
REQ-024 FEED SHALL run steps 0 .. K+2N-3, K+2N-2 advancing steps in total; the advancing step t=K+2N-3 SHALL transition to DONE.
REQ-025 In IDLE and DONE, pe_hold_o SHALL be 1 and feed_en_o SHALL be 0.
REQ-026 In DONE, result_valid_o SHALL be 1.
REQ-027 In DONE, result_valid_o AND result_ready_i SHALL pulse done_o for 1 cycle and transition to IDLE at that edge.
REQ-028 result_ready_i SHALL be ignored outside DONE.
REQ-029 The step counter SHALL be CNT_W+1 bits wide and SHALL never wrap for legal parameters.
REQ-030 K SHALL remain stable for the whole job, independent of later changes on mat_width_i.
REQ-031 Back-to-back jobs: a start_i asserted in the same cycle as the done_o pulse SHALL be ignored; the earliest accepted start is the next cycle in IDLE.

Reset
REQ-032 rst=1 SHALL force IDLE from any state, including mid-FEED and DONE, at the next edge.
REQ-033 Reset values: step=0, K=0, pe_clr_o=0, pe_hold_o=1, feed_en_o=0, busy_o=0, result_valid_o=0, done_o=0.
REQ-034 A job aborted by reset SHALL NOT produce done_o.

Configuration
REQ-035 With PE_CTRL_PERF_EN defined, the block SHALL add output stall_cnt_o, 32 bits wide, counting stall cycles of the current job.
REQ-036 stall_cnt_o SHALL clear in CLEAR and on rst, saturate at 2^32-1, and hold its value through DONE and IDLE.
REQ-037 Without PE_CTRL_PERF_EN defined, the port and counter SHALL be absent and the remaining behaviour identical.

Verification
REQ-038 N=4, K=3, in_valid_i=1, start in IDLE at cycle 0 -> pe_clr_o at cycle 1; FEED cycles 2..10 (9 steps); feed_en_o at t=0 is 0001, t=3 is 1110, t=6..8 is 0000; result_valid_o from cycle 11.
REQ-039 Same job with in_valid_i=0 for 2 cycles at t=2 -> pe_hold_o=1 and t held at 2 for those cycles; DONE entered 2 cycles later; stall_cnt_o=2 (macro on).
REQ-040 in_valid_i=0 during drain t=7 (N=4, K=3) -> no stall; pe_hold_o=0 and t advances.
REQ-041 K=0 -> CLEAR then DONE directly, feed_en_o never nonzero; result_ready_i=1 -> done_o pulse and IDLE.
REQ-042 rst asserted at t=4 of FEED -> next cycle IDLE, all outputs at reset values, no done_o; a following start with K=2 completes normally.
REQ-043 result_ready_i held 0 in DONE for 5 cycles -> result_valid_o stays 1 and pe_hold_o stays 1; start_i pulses during that time are ignored.
